// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// The arbiter takes the slave view; whatever drives requests and models memory takes master.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              CpuMemRead;
    logic              CpuMemWrite;
    logic [DATA_W-1:0] CpuAddress;
    logic [DATA_W-1:0] CpuWriteData;
    logic [1:0]        CpuByteSel;
    logic [DATA_W-1:0] CpuReadData;
    logic              CpuStall;

    logic              ExtReq;
    logic              ExtWrite;
    logic [DATA_W-1:0] ExtAddress;
    logic [DATA_W-1:0] ExtWriteData;
    logic [1:0]        ExtByteSel;
    logic              ExtGrant;
    logic              ExtDone;
    logic [DATA_W-1:0] ExtReadData;

    logic [DATA_W-1:0] MemAddress;
    logic [DATA_W-1:0] MemWriteData;
    logic [1:0]        MemByteSel;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] MemReadData;

    modport slave (
        input  CpuMemRead, CpuMemWrite, CpuAddress, CpuWriteData, CpuByteSel,
        output CpuReadData, CpuStall,
        input  ExtReq, ExtWrite, ExtAddress, ExtWriteData, ExtByteSel,
        output ExtGrant, ExtDone, ExtReadData,
        output MemAddress, MemWriteData, MemByteSel, MemRead, MemWrite,
        input  MemReadData
    );

    modport master (
        output CpuMemRead, CpuMemWrite, CpuAddress, CpuWriteData, CpuByteSel,
        input  CpuReadData, CpuStall,
        output ExtReq, ExtWrite, ExtAddress, ExtWriteData, ExtByteSel,
        input  ExtGrant, ExtDone, ExtReadData,
        input  MemAddress, MemWriteData, MemByteSel, MemRead, MemWrite,
        output MemReadData
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the single-port data memory between the CPU MEM stage and
// an external (debug/DMA) port; each access drives the memory for ACCESS_CYCLES cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | memory idle, arbitrating every cycle, Mem* strobes low
// S_CPU    | CPU command latched and driven, cnt counts access cycles
// S_EXT    | external command latched and driven, cnt counts access cycles
module dmem_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int DATA_W        = 32
) (
    input  logic           Clock,
    input  logic           Reset,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_EXT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_ext_q, last_ext_d;
    logic [DATA_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [1:0]        cmd_bsel_q, cmd_bsel_d;
    logic              cmd_rd_q, cmd_rd_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

    logic cpu_req;
    logic busy;
    logic done;
    logic cpu_pend;
    logic ext_pend;
    logic grant_cpu;
    logic grant_ext;

    always_comb begin
        cpu_req   = bus.CpuMemRead | bus.CpuMemWrite;
        busy      = (state_q != S_IDLE);
        done      = busy && (cnt_q == CNT_LAST);
        // The owner that is finishing cannot win the arbitration on its own completion edge.
        cpu_pend  = cpu_req && (state_q != S_CPU);
        ext_pend  = bus.ExtReq && (state_q != S_EXT);
        grant_cpu = cpu_pend && (!ext_pend || last_ext_q);
        grant_ext = ext_pend && !grant_cpu;

        state_d     = state_q;
        cnt_d       = cnt_q;
        last_ext_d  = last_ext_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_bsel_d  = cmd_bsel_q;
        cmd_rd_d    = cmd_rd_q;
        cmd_wr_d    = cmd_wr_q;
        ext_rdata_d = ext_rdata_q;

        if ((state_q == S_EXT) && done && cmd_rd_q) begin
            ext_rdata_d = bus.MemReadData;
        end

        if (!busy || done) begin
            cnt_d = '0;
            if (grant_cpu) begin
                state_d     = S_CPU;
                last_ext_d  = 1'b0;
                cmd_addr_d  = bus.CpuAddress;
                cmd_wdata_d = bus.CpuWriteData;
                cmd_bsel_d  = bus.CpuByteSel;
                cmd_wr_d    = bus.CpuMemWrite;
                cmd_rd_d    = bus.CpuMemRead && !bus.CpuMemWrite;
            end else if (grant_ext) begin
                state_d     = S_EXT;
                last_ext_d  = 1'b1;
                cmd_addr_d  = bus.ExtAddress;
                cmd_wdata_d = bus.ExtWriteData;
                cmd_bsel_d  = bus.ExtByteSel;
                cmd_wr_d    = bus.ExtWrite;
                cmd_rd_d    = !bus.ExtWrite;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_ext_q  <= 1'b1;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_bsel_q  <= '0;
            cmd_rd_q    <= 1'b0;
            cmd_wr_q    <= 1'b0;
            ext_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_ext_q  <= last_ext_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_bsel_q  <= cmd_bsel_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_wr_q    <= cmd_wr_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

    // Strobes and handshakes are forced low for as long as Reset is held, not just after the edge.
    always_comb begin
        bus.MemAddress   = cmd_addr_q;
        bus.MemWriteData = cmd_wdata_q;
        bus.MemByteSel   = cmd_bsel_q;
        bus.MemRead      = Reset && busy && cmd_rd_q;
        bus.MemWrite     = Reset && busy && cmd_wr_q;
        bus.CpuReadData  = bus.MemReadData;
        bus.CpuStall     = Reset && cpu_req && !((state_q == S_CPU) && done);
        bus.ExtGrant     = Reset && (state_q == S_EXT);
        bus.ExtDone      = Reset && (state_q == S_EXT) && done;
        bus.ExtReadData  = ext_rdata_q;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scenarios with literal expectations, then a randomized run checked every
// cycle against a transaction-level model of the round-robin memory sharing.
module tb_dmem_arbiter;
    localparam int ACC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dmem_arbiter_if #(.DATA_W(32)) bus ();

    dmem_arbiter #(.ACCESS_CYCLES(ACC), .DATA_W(32)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    assign bus.MemReadData = memf(bus.MemAddress);

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.CpuMemRead = 0; bus.CpuMemWrite = 0; bus.CpuAddress = 0;
        bus.CpuWriteData = 0; bus.CpuByteSel = 0;
        bus.ExtReq = 0; bus.ExtWrite = 0; bus.ExtAddress = 0;
        bus.ExtWriteData = 0; bus.ExtByteSel = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        next();
        next();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.CpuMemRead = 1; bus.ExtReq = 1; bus.ExtWrite = 1;
        next();
        @(negedge clk);
        checks++; if (bus.CpuStall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", bus.CpuStall); end
        checks++; if (bus.ExtGrant !== 1'b0) begin errors++; $display("FAIL rst_grant got %b want 0", bus.ExtGrant); end
        checks++; if (bus.ExtDone !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.ExtDone); end
        checks++; if ({bus.MemRead, bus.MemWrite} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b want 00", {bus.MemRead, bus.MemWrite}); end
        checks++; if (bus.ExtReadData !== 32'h0) begin errors++; $display("FAIL rst_xrd got %h want 0", bus.ExtReadData); end
        checks++; if (bus.MemAddress !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", bus.MemAddress); end
        clear_inputs();
        next();
        rst_n = 1;
    endtask

    task automatic test_cpu_read();
        do_reset();
        bus.CpuMemRead = 1; bus.CpuAddress = 32'h10; bus.CpuByteSel = 2'b10;
        @(negedge clk);
        checks++; if (bus.CpuStall !== 1'b1) begin errors++; $display("FAIL cpurd_t0_stall got %b want 1", bus.CpuStall); end
        checks++; if (bus.MemRead !== 1'b0) begin errors++; $display("FAIL cpurd_t0_memrd got %b want 0", bus.MemRead); end
        next();
        @(negedge clk);
        checks++; if (bus.CpuStall !== 1'b1) begin errors++; $display("FAIL cpurd_t1_stall got %b want 1", bus.CpuStall); end
        checks++; if (bus.MemRead !== 1'b1 || bus.MemAddress !== 32'h10) begin errors++; $display("FAIL cpurd_t1_mem got rd=%b addr=%h want rd=1 addr=10", bus.MemRead, bus.MemAddress); end
        checks++; if (bus.MemByteSel !== 2'b10) begin errors++; $display("FAIL cpurd_bsel got %b want 10", bus.MemByteSel); end
        next();
        @(negedge clk);
        checks++; if (bus.CpuStall !== 1'b0) begin errors++; $display("FAIL cpurd_t2_stall got %b want 0", bus.CpuStall); end
        checks++; if (bus.MemRead !== 1'b1) begin errors++; $display("FAIL cpurd_t2_memrd got %b want 1", bus.MemRead); end
        checks++; if (bus.CpuReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL cpurd_data got %h want deadbeef", bus.CpuReadData); end
        next();
        bus.CpuMemRead = 0;
        @(negedge clk);
        checks++; if (bus.MemRead !== 1'b0) begin errors++; $display("FAIL cpurd_t3_memrd got %b want 0", bus.MemRead); end
    endtask

    task automatic test_ext_write();
        do_reset();
        bus.ExtReq = 1; bus.ExtWrite = 1; bus.ExtAddress = 32'h20;
        bus.ExtWriteData = 32'h12345678; bus.ExtByteSel = 2'b00;
        next();
        bus.ExtWrite = 0; bus.ExtAddress = 32'hFFFF_FFF0;
        bus.ExtWriteData = 32'hBAD0_BAD0; bus.ExtByteSel = 2'b11;
        for (int t = 1; t <= 2; t++) begin
            @(negedge clk);
            checks++; if ({bus.MemWrite, bus.MemRead} !== 2'b10) begin errors++; $display("FAIL extwr_t%0d_strobes got %b want 10", t, {bus.MemWrite, bus.MemRead}); end
            checks++; if (bus.MemAddress !== 32'h20 || bus.MemWriteData !== 32'h12345678 || bus.MemByteSel !== 2'b00) begin errors++; $display("FAIL extwr_t%0d_cmd got %h %h %b want 20 12345678 00", t, bus.MemAddress, bus.MemWriteData, bus.MemByteSel); end
            checks++; if (bus.ExtGrant !== 1'b1) begin errors++; $display("FAIL extwr_t%0d_grant got %b want 1", t, bus.ExtGrant); end
            checks++; if (bus.ExtDone !== (t == 2)) begin errors++; $display("FAIL extwr_t%0d_done got %b want %b", t, bus.ExtDone, (t == 2)); end
            next();
        end
        bus.ExtReq = 0;
        @(negedge clk);
        checks++; if ({bus.ExtGrant, bus.ExtDone, bus.MemWrite} !== 3'b000) begin errors++; $display("FAIL extwr_t3 got %b want 000", {bus.ExtGrant, bus.ExtDone, bus.MemWrite}); end
        next();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.CpuMemRead = 1; bus.CpuAddress = 32'h30;
        bus.ExtReq = 1; bus.ExtWrite = 0; bus.ExtAddress = 32'h44;
        @(negedge clk);
        checks++; if (bus.CpuStall !== 1'b1 || bus.ExtGrant !== 1'b0) begin errors++; $display("FAIL b2b_t0 got stall=%b grant=%b want 1 0", bus.CpuStall, bus.ExtGrant); end
        next();
        @(negedge clk);
        checks++; if (bus.MemRead !== 1'b1 || bus.MemAddress !== 32'h30 || bus.ExtGrant !== 1'b0) begin errors++; $display("FAIL b2b_t1 got rd=%b addr=%h grant=%b want 1 30 0", bus.MemRead, bus.MemAddress, bus.ExtGrant); end
        next();
        @(negedge clk);
        checks++; if (bus.CpuStall !== 1'b0 || bus.CpuReadData !== memf(32'h30)) begin errors++; $display("FAIL b2b_t2 got stall=%b data=%h want 0 %h", bus.CpuStall, bus.CpuReadData, memf(32'h30)); end
        next();
        bus.CpuMemRead = 0;
        @(negedge clk);
        checks++; if (bus.ExtGrant !== 1'b1 || bus.MemAddress !== 32'h44 || bus.ExtDone !== 1'b0) begin errors++; $display("FAIL b2b_t3 got grant=%b addr=%h done=%b want 1 44 0", bus.ExtGrant, bus.MemAddress, bus.ExtDone); end
        next();
        @(negedge clk);
        checks++; if (bus.ExtDone !== 1'b1) begin errors++; $display("FAIL b2b_t4_done got %b want 1", bus.ExtDone); end
        next();
        bus.ExtReq = 0;
        @(negedge clk);
        checks++; if (bus.ExtReadData !== memf(32'h44) || bus.ExtGrant !== 1'b0) begin errors++; $display("FAIL b2b_t5 got xrd=%h grant=%b want %h 0", bus.ExtReadData, bus.ExtGrant, memf(32'h44)); end
        next();
    endtask

    task automatic test_fairness();
        int  starts = 0;
        int  prev_owner = -1;
        logic prev_busy = 0;
        logic prev_fin = 0;
        logic ext_block = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            bus.CpuMemRead = 1; bus.CpuAddress = $urandom;
            bus.ExtReq = !ext_block; bus.ExtWrite = 0; bus.ExtAddress = $urandom;
            @(negedge clk);
            if (bus.MemRead && (!prev_busy || prev_fin)) begin
                checks++;
                if (prev_owner < 0) begin
                    if (bus.ExtGrant !== 1'b0) begin errors++; $display("FAIL rr_first got ext=%b want 0", bus.ExtGrant); end
                end else if (int'(bus.ExtGrant) == prev_owner) begin
                    errors++; $display("FAIL rr_alternate got ext=%b want %0d", bus.ExtGrant, 1 - prev_owner);
                end
                prev_owner = int'(bus.ExtGrant);
                starts++;
            end
            prev_busy = bus.MemRead;
            prev_fin  = bus.ExtDone || (bus.MemRead && !bus.ExtGrant && !bus.CpuStall);
            ext_block = bus.ExtDone;
            next();
        end
        checks++; if (starts < 6) begin errors++; $display("FAIL rr_starts got %0d want >=6", starts); end
        clear_inputs();
        next();
        next();
    endtask

    task automatic test_reset_abort();
        do_reset();
        bus.CpuMemRead = 1; bus.CpuAddress = 32'h44;
        bus.ExtReq = 1; bus.ExtWrite = 0; bus.ExtAddress = 32'h44;
        for (int i = 0; i < 5; i++) next();
        clear_inputs();
        for (int i = 0; i < 3; i++) next();
        @(negedge clk);
        checks++; if (bus.ExtReadData !== memf(32'h44)) begin errors++; $display("FAIL abort_pre_xrd got %h want %h", bus.ExtReadData, memf(32'h44)); end
        next();
        bus.ExtReq = 1; bus.ExtWrite = 1; bus.ExtAddress = 32'h50; bus.ExtWriteData = 32'hCAFEF00D;
        next();
        bus.ExtReq = 0;
        @(negedge clk);
        checks++; if (bus.MemWrite !== 1'b1 || bus.ExtGrant !== 1'b1) begin errors++; $display("FAIL abort_cnt0 got wr=%b grant=%b want 1 1", bus.MemWrite, bus.ExtGrant); end
        rst_n = 0;
        #1;
        checks++; if (bus.MemWrite !== 1'b0 || bus.ExtGrant !== 1'b0) begin errors++; $display("FAIL abort_during got wr=%b grant=%b want 0 0", bus.MemWrite, bus.ExtGrant); end
        next();
        rst_n = 1;
        @(negedge clk);
        checks++; if ({bus.MemWrite, bus.ExtGrant, bus.ExtDone} !== 3'b000) begin errors++; $display("FAIL abort_after got %b want 000", {bus.MemWrite, bus.ExtGrant, bus.ExtDone}); end
        checks++; if (bus.ExtReadData !== 32'h0) begin errors++; $display("FAIL abort_xrd got %h want 0", bus.ExtReadData); end
        for (int i = 0; i < 4; i++) begin
            next();
            @(negedge clk);
            checks++; if (bus.MemWrite !== 1'b0) begin errors++; $display("FAIL abort_replay c%0d got %b want 0", i, bus.MemWrite); end
        end
        next();
    endtask

    task automatic test_cpu_rw_both();
        do_reset();
        bus.CpuMemRead = 1; bus.CpuMemWrite = 1; bus.CpuAddress = 32'h40;
        bus.CpuWriteData = 32'hA5A5A5A5; bus.CpuByteSel = 2'b01;
        next();
        for (int t = 1; t <= 2; t++) begin
            @(negedge clk);
            checks++; if ({bus.MemWrite, bus.MemRead} !== 2'b10 || bus.MemWriteData !== 32'hA5A5A5A5 || bus.MemAddress !== 32'h40) begin errors++; $display("FAIL rw_t%0d got wr=%b rd=%b d=%h a=%h want 1 0 a5a5a5a5 40", t, bus.MemWrite, bus.MemRead, bus.MemWriteData, bus.MemAddress); end
            checks++; if (bus.CpuStall !== (t != 2)) begin errors++; $display("FAIL rw_t%0d_stall got %b want %b", t, bus.CpuStall, (t != 2)); end
            next();
        end
        clear_inputs();
        next();
    endtask

    task automatic test_random();
        int          m_owner, m_left, m_last, pick;
        logic [31:0] m_addr, m_wdata, m_xrd;
        logic [1:0]  m_bs;
        logic        m_rd, m_wr, busy, fin, cpu_req, cp, ep, ext_block;
        logic        e_stall, e_grant, e_done, e_mrd, e_mwr;
        do_reset();
        m_owner = 0; m_left = 0; m_last = 2; m_addr = 0; m_wdata = 0; m_bs = 0;
        m_rd = 0; m_wr = 0; m_xrd = 0; ext_block = 0;
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            bus.CpuMemRead = ($urandom_range(0, 2) == 0); bus.CpuMemWrite = ($urandom_range(0, 3) == 0);
            bus.CpuAddress = $urandom; bus.CpuWriteData = $urandom; bus.CpuByteSel = 2'($urandom);
            bus.ExtReq = !ext_block && ($urandom_range(0, 2) == 0); bus.ExtWrite = 1'($urandom);
            bus.ExtAddress = $urandom; bus.ExtWriteData = $urandom; bus.ExtByteSel = 2'($urandom);
            cpu_req = bus.CpuMemRead || bus.CpuMemWrite;
            busy = (m_owner != 0);
            fin = busy && (m_left == 1);
            e_stall = rst_n && cpu_req && !(m_owner == 1 && fin);
            e_grant = rst_n && (m_owner == 2);
            e_done  = e_grant && fin;
            e_mrd   = rst_n && busy && m_rd;
            e_mwr   = rst_n && busy && m_wr;
            @(negedge clk);
            checks++; if (bus.CpuStall !== e_stall) begin errors++; $display("FAIL rnd%0d_stall got %b want %b", c, bus.CpuStall, e_stall); end
            checks++; if (bus.ExtGrant !== e_grant || bus.ExtDone !== e_done) begin errors++; $display("FAIL rnd%0d_ext got g=%b d=%b want g=%b d=%b", c, bus.ExtGrant, bus.ExtDone, e_grant, e_done); end
            checks++; if (bus.MemRead !== e_mrd || bus.MemWrite !== e_mwr) begin errors++; $display("FAIL rnd%0d_strobe got r=%b w=%b want r=%b w=%b", c, bus.MemRead, bus.MemWrite, e_mrd, e_mwr); end
            checks++; if (bus.MemAddress !== m_addr || bus.MemWriteData !== m_wdata || bus.MemByteSel !== m_bs) begin errors++; $display("FAIL rnd%0d_cmd got %h %h %b want %h %h %b", c, bus.MemAddress, bus.MemWriteData, bus.MemByteSel, m_addr, m_wdata, m_bs); end
            checks++; if (bus.ExtReadData !== m_xrd) begin errors++; $display("FAIL rnd%0d_xrd got %h want %h", c, bus.ExtReadData, m_xrd); end
            checks++; if (bus.CpuReadData !== memf(m_addr)) begin errors++; $display("FAIL rnd%0d_crd got %h want %h", c, bus.CpuReadData, memf(m_addr)); end
            if (!rst_n) begin
                m_owner = 0; m_left = 0; m_last = 2; m_addr = 0; m_wdata = 0; m_bs = 0;
                m_rd = 0; m_wr = 0; m_xrd = 0;
            end else begin
                if (fin && m_owner == 2 && m_rd) m_xrd = memf(m_addr);
                if (!busy || fin) begin
                    cp = cpu_req && (m_owner != 1);
                    ep = bus.ExtReq && (m_owner != 2);
                    pick = 0;
                    if (cp && ep) pick = (m_last == 1) ? 2 : 1;
                    else if (cp) pick = 1;
                    else if (ep) pick = 2;
                    if (pick == 1) begin
                        m_addr = bus.CpuAddress; m_wdata = bus.CpuWriteData; m_bs = bus.CpuByteSel;
                        m_wr = bus.CpuMemWrite; m_rd = !bus.CpuMemWrite;
                    end else if (pick == 2) begin
                        m_addr = bus.ExtAddress; m_wdata = bus.ExtWriteData; m_bs = bus.ExtByteSel;
                        m_wr = bus.ExtWrite; m_rd = !bus.ExtWrite;
                    end
                    if (pick != 0) m_last = pick;
                    m_owner = pick;
                    m_left = ACC;
                end else begin
                    m_left--;
                end
            end
            ext_block = e_done;
            next();
        end
        rst_n = 1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_ext_write();
        test_back_to_back();
        test_fairness();
        test_reset_abort();
        test_cpu_rw_both();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
